// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared widths, defaults and write-request type for the write-port arbiter
package regfile_wb_arbiter_pkg;
  localparam int REG_IDX_W            = 5;
  localparam int DATA_W               = 32;
  localparam int DEFAULT_DEPTH        = 2;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [REG_IDX_W-1:0] regidx;
    logic [DATA_W-1:0]    data;
  } wr_req_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// rtl/regfile_wb_fifo.sv - in-order circular buffer of pending secondary writes with youngest-match lookup
module regfile_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  wr_req_t              push_req,
  input  logic                 pop,
  output wr_req_t              head,
  output logic                 empty,
  output logic                 full,
  input  logic [REG_IDX_W-1:0] rd_reg1,
  input  logic [REG_IDX_W-1:0] rd_reg2,
  output logic                 hit1,
  output logic                 hit2,
  output logic [DATA_W-1:0]    data1,
  output logic [DATA_W-1:0]    data2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] idx;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    idx   = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (rd_reg1 != '0 && mem[idx].regidx == rd_reg1) begin
          hit1  = 1'b1;
          data1 = mem[idx].data;
        end
        if (rd_reg2 != '0 && mem[idx].regidx == rd_reg2) begin
          hit2  = 1'b1;
          data2 = mem[idx].data;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between writeback and queued long-latency writes
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 sec_valid,
  output logic                 sec_ready,
  input  logic [REG_IDX_W-1:0] sec_reg,
  input  logic [DATA_W-1:0]    sec_data,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  input  logic [REG_IDX_W-1:0] rd_reg1,
  input  logic [REG_IDX_W-1:0] rd_reg2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [DATA_W-1:0]    fwd_data1,
  output logic [DATA_W-1:0]    fwd_data2,
  output logic                 wb_stall,
  input  logic                 halted,
  output logic                 drained
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic              prim;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  wr_req_t           head;
  wr_req_t           push_req;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [SW-1:0]     starve_cnt;

  // A writeback to r0 is a no-op, so it leaves the port free for the queue.
  assign prim      = wb_valid && (wb_reg != '0);
  assign sec_ready = reset && !fifo_full;
  assign fifo_push = sec_valid && sec_ready && (sec_reg != '0);
  assign fifo_pop  = !prim && !fifo_empty;
  assign push_req  = '{regidx: sec_reg, data: sec_data};

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_req (push_req),
    .pop      (fifo_pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .rd_reg1  (rd_reg1),
    .rd_reg2  (rd_reg2),
    .hit1     (hit1),
    .hit2     (hit2),
    .data1    (data1),
    .data2    (data2)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (reset) begin
      if (prim) begin
        rf_we    = 1'b1;
        rf_waddr = wb_reg;
        rf_wdata = wb_data;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_waddr = head.regidx;
        rf_wdata = head.data;
      end
    end
  end

  assign fwd_hit1  = reset && hit1;
  assign fwd_hit2  = reset && hit2;
  assign fwd_data1 = reset ? data1 : '0;
  assign fwd_data2 = reset ? data2 : '0;
  assign drained   = reset && halted && fifo_empty && !wb_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else if (prim && !fifo_empty) begin
      if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
        starve_cnt <= '0;
        wb_stall   <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
        wb_stall   <= 1'b0;
      end
    end else begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end
  end

  a_no_wb_during_stall: assert property (@(posedge clock) disable iff (!reset) !(wb_stall && wb_valid));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - vector table, corner sequences and randomized model check for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_reg;
  logic [31:0] sec_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic        wb_stall;
  logic        halted;
  logic        drained;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_reg(sec_reg), .sec_data(sec_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .wb_stall(wb_stall), .halted(halted), .drained(drained)
  );

  typedef struct {
    logic        wv; logic [4:0] wr; logic [31:0] wd;
    logic        sv; logic [4:0] sr; logic [31:0] sd;
    logic [4:0]  r1; logic [4:0] r2; logic h;
    logic        e_rdy; logic e_we; logic [4:0] e_wa; logic [31:0] e_wd;
    logic        e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2;
    logic        e_st; logic e_dr;
  } vec_t;

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [9];
  vec_t v;
  ent_t q [$];
  int   starve;
  logic m_stall;
  logic prim;
  logic blocked;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // Drive at posedge+1, compare at posedge+5, then advance one clock.
  task automatic run(input string tag, input vec_t x);
    wb_valid = x.wv; wb_reg = x.wr; wb_data = x.wd;
    sec_valid = x.sv; sec_reg = x.sr; sec_data = x.sd;
    rd_reg1 = x.r1; rd_reg2 = x.r2; halted = x.h;
    #4;
    chk({tag, ".sec_ready"}, sec_ready, x.e_rdy);
    chk({tag, ".rf_we"}, rf_we, x.e_we);
    chk({tag, ".rf_waddr"}, rf_waddr, x.e_wa);
    chk({tag, ".rf_wdata"}, rf_wdata, x.e_wd);
    chk({tag, ".fwd_hit1"}, fwd_hit1, x.e_h1);
    chk({tag, ".fwd_data1"}, fwd_data1, x.e_d1);
    chk({tag, ".fwd_hit2"}, fwd_hit2, x.e_h2);
    chk({tag, ".fwd_data2"}, fwd_data2, x.e_d2);
    chk({tag, ".wb_stall"}, wb_stall, x.e_st);
    chk({tag, ".drained"}, drained, x.e_dr);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // wv wr wd | sv sr sd | r1 r2 h | rdy we wa wd | h1 d1 | h2 d2 | st dr
    tbl[0] = '{0, 0, 0,     1, 5, 32'hDEADBEEF, 5, 0, 0,  1, 0, 0, 0,             0, 0,             0, 0,    0, 0};
    tbl[1] = '{0, 0, 0,     0, 0, 0,            5, 0, 0,  1, 1, 5, 32'hDEADBEEF,  1, 32'hDEADBEEF,  0, 0,    0, 0};
    tbl[2] = '{1, 1, 'hA1,  1, 3, 'h11,         3, 0, 0,  1, 1, 1, 'hA1,          0, 0,             0, 0,    0, 0};
    tbl[3] = '{1, 2, 'hA2,  1, 3, 'h22,         3, 0, 0,  1, 1, 2, 'hA2,          1, 'h11,          0, 0,    0, 0};
    tbl[4] = '{1, 1, 'hA3,  1, 9, 'h99,         3, 9, 0,  0, 1, 1, 'hA3,          1, 'h22,          0, 0,    0, 0};
    tbl[5] = '{0, 0, 0,     0, 0, 0,            3, 9, 0,  0, 1, 3, 'h11,          1, 'h22,          0, 0,    0, 0};
    tbl[6] = '{1, 0, 'h55,  0, 0, 0,            3, 0, 0,  1, 1, 3, 'h22,          1, 'h22,          0, 0,    0, 0};
    tbl[7] = '{0, 0, 0,     1, 0, 'h77,         0, 3, 0,  1, 0, 0, 0,             0, 0,             0, 0,    0, 0};
    tbl[8] = '{0, 0, 0,     0, 0, 0,            0, 0, 1,  1, 0, 0, 0,             0, 0,             0, 0,    0, 1};

    // Reset state: outputs held low even with a live primary request and halted set.
    reset = 1'b0;
    v = '{1, 1, 'hF0, 1, 2, 'h2, 1, 2, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    #1;
    run("reset0", v);
    run("reset1", v);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run($sformatf("tbl%0d", i), tbl[i]);

    // Starvation: one entry blocked by four primary cycles forces a one-cycle stall.
    v = '{1, 1, 'hB0, 1, 7, 'h7, 7, 0, 0,  1, 1, 1, 'hB0, 0, 0, 0, 0, 0, 0};
    run("starveA", v);
    for (int k = 0; k < 4; k++) begin
      v = '{1, 2, 'hC0 + k, 0, 0, 0, 7, 0, 0,  1, 1, 2, 'hC0 + k, 1, 'h7, 0, 0, 0, 0};
      run($sformatf("starveB%0d", k), v);
    end
    v = '{0, 0, 0, 0, 0, 0, 7, 0, 0,  1, 1, 7, 'h7, 1, 'h7, 0, 0, 1, 0};
    run("starveF", v);
    v = '{1, 1, 'hD0, 0, 0, 0, 7, 0, 0,  1, 1, 1, 'hD0, 0, 0, 0, 0, 0, 0};
    run("starveG", v);

    // Halted drain with two queued entries.
    v = '{1, 1, 'hE1, 1, 4, 'h44, 4, 6, 0,  1, 1, 1, 'hE1, 0, 0, 0, 0, 0, 0};
    run("haltH1", v);
    v = '{1, 2, 'hE2, 1, 6, 'h66, 4, 6, 0,  1, 1, 2, 'hE2, 1, 'h44, 0, 0, 0, 0};
    run("haltH2", v);
    v = '{0, 0, 0, 0, 0, 0, 4, 6, 1,  0, 1, 4, 'h44, 1, 'h44, 1, 'h66, 0, 0};
    run("haltD1", v);
    v = '{0, 0, 0, 0, 0, 0, 4, 6, 1,  1, 1, 6, 'h66, 0, 0, 1, 'h66, 0, 0};
    run("haltD2", v);
    v = '{0, 0, 0, 0, 0, 0, 4, 6, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    run("haltD3", v);

    // Reset mid-operation with two entries queued; nothing stale survives it.
    v = '{1, 1, 'hE1, 1, 4, 'h44, 4, 6, 0,  1, 1, 1, 'hE1, 0, 0, 0, 0, 0, 0};
    run("rstR1", v);
    v = '{1, 2, 'hE2, 1, 6, 'h66, 4, 6, 0,  1, 1, 2, 'hE2, 1, 'h44, 0, 0, 0, 0};
    run("rstR2", v);
    reset = 1'b0;
    v = '{1, 1, 'hE3, 0, 0, 0, 4, 6, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("rstLow0", v);
    run("rstLow1", v);
    reset = 1'b1;
    v = '{0, 0, 0, 0, 0, 0, 4, 6, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("rstRel", v);

    // Randomized traffic against a queue-based reference model.
    q.delete();
    starve  = 0;
    m_stall = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v.wv = !m_stall && ($urandom_range(0, 2) != 0);
      v.wr = 5'($urandom_range(0, 7));
      v.wd = $urandom;
      v.sv = ($urandom_range(0, 1) == 1);
      v.sr = 5'($urandom_range(0, 7));
      v.sd = $urandom;
      v.r1 = 5'($urandom_range(0, 7));
      v.r2 = 5'($urandom_range(0, 7));
      v.h  = ($urandom_range(0, 3) == 0);

      prim    = v.wv && (v.wr != 0);
      v.e_rdy = (q.size() < DEPTH);
      v.e_we  = prim || (q.size() > 0);
      v.e_wa  = prim ? v.wr : (q.size() > 0 ? q[0].r : 5'd0);
      v.e_wd  = prim ? v.wd : (q.size() > 0 ? q[0].d : 32'd0);
      v.e_h1 = 0; v.e_d1 = 0; v.e_h2 = 0; v.e_d2 = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!v.e_h1 && v.r1 != 0 && q[i].r == v.r1) begin v.e_h1 = 1; v.e_d1 = q[i].d; end
        if (!v.e_h2 && v.r2 != 0 && q[i].r == v.r2) begin v.e_h2 = 1; v.e_d2 = q[i].d; end
      end
      v.e_st = m_stall;
      v.e_dr = v.h && (q.size() == 0) && !v.wv;

      run($sformatf("rnd%0d", n), v);

      blocked = prim && (q.size() > 0);
      if (!prim && q.size() > 0) q.delete(0);
      if (v.sv && v.e_rdy && v.sr != 0) q.push_back('{v.sr, v.sd});
      if (blocked) begin
        starve++;
        m_stall = (starve == LIMIT);
        if (m_stall) starve = 0;
      end else begin
        starve  = 0;
        m_stall = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
